// File: rtl/combat_judge.sv
// Two-player combat referee: hit detection, registered hit flags,
// saturating health and the FIGHT/KO/DONE round sequencer.
module combat_judge #(
  parameter int MAX_HEALTH = 100,
  parameter int HP_W       = 7,
  parameter int DMG_BASIC  = 10,
  parameter int DMG_DIR    = 15,
  parameter int DMG_CHIP   = 2,
  parameter int KO_FRAMES  = 90
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      p1_state,
  input  logic [3:0]      p2_state,
  input  logic [39:0]     p1_basic_box,
  input  logic [39:0]     p2_basic_box,
  input  logic [39:0]     p1_dir_box,
  input  logic [39:0]     p2_dir_box,
  input  logic [39:0]     p1_hurt_box,
  input  logic [39:0]     p2_hurt_box,
  input  logic            restart,
  output logic [1:0]      p1_hitFlag,
  output logic [1:0]      p2_hitFlag,
  output logic [HP_W-1:0] p1_health,
  output logic [HP_W-1:0] p2_health,
  output logic [1:0]      round_state,
  output logic [1:0]      winner
);

  typedef enum logic [1:0] {
    FIGHT = 2'b00,
    KO    = 2'b01,
    DONE  = 2'b10
  } round_t;

  localparam int CW = (KO_FRAMES > 1) ? $clog2(KO_FRAMES) : 1;
  localparam logic [CW-1:0]   KO_LAST = CW'(KO_FRAMES - 1);
  localparam logic [HP_W-1:0] HP_MAX  = HP_W'(MAX_HEALTH);
  localparam logic [HP_W-1:0] D_BASIC = HP_W'(DMG_BASIC);
  localparam logic [HP_W-1:0] D_DIR   = HP_W'(DMG_DIR);
  localparam logic [HP_W-1:0] D_CHIP  = HP_W'(DMG_CHIP);

  localparam logic [3:0] ST_BACK  = 4'd2;
  localparam logic [3:0] ST_B_ACT = 4'd4;
  localparam logic [3:0] ST_D_ACT = 4'd7;
  localparam logic [3:0] ST_HSTUN = 4'd9;
  localparam logic [3:0] ST_BSTUN = 4'd10;

  round_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      p1_flag_q, p1_flag_d;
  logic [1:0]      p2_flag_q, p2_flag_d;
  logic [HP_W-1:0] p1_hp_q, p1_hp_d;
  logic [HP_W-1:0] p2_hp_q, p2_hp_d;
  logic            p1_conn_q, p1_conn_d;
  logic            p2_conn_q, p2_conn_d;
  logic [1:0]      win_q, win_d;

  logic            p1_act, p2_act;
  logic            p1_vuln, p2_vuln;
  logic            hit_en;
  logic            att_p1, att_p2;
  logic [HP_W-1:0] dmg_p1, dmg_p2;

  // {x1,x2,y1,y2}, inclusive on every edge
  function automatic logic overlap(
    input logic [39:0] a,
    input logic [39:0] b
  );
    return (a[39:30] <= b[29:20]) &&
           (b[39:30] <= a[29:20]) &&
           (a[19:10] <= b[9:0])   &&
           (b[19:10] <= a[9:0]);
  endfunction

  function automatic logic [HP_W-1:0] sat_sub(
    input logic [HP_W-1:0] h,
    input logic [HP_W-1:0] d
  );
    return (h > d) ? (h - d) : '0;
  endfunction

  always_comb begin
    p1_act = ((p1_state == ST_B_ACT) &&
              overlap(p1_basic_box, p2_hurt_box)) ||
             ((p1_state == ST_D_ACT) &&
              overlap(p1_dir_box, p2_hurt_box));
    p2_act = ((p2_state == ST_B_ACT) &&
              overlap(p2_basic_box, p1_hurt_box)) ||
             ((p2_state == ST_D_ACT) &&
              overlap(p2_dir_box, p1_hurt_box));
    p1_vuln = (p1_state != ST_HSTUN) &&
              (p1_state != ST_BSTUN);
    p2_vuln = (p2_state != ST_HSTUN) &&
              (p2_state != ST_BSTUN);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    unique case (state_q)
      FIGHT: begin
        if ((p1_hp_q == '0) || (p2_hp_q == '0)) begin
          state_d = KO;
          cnt_d   = '0;
          win_d   = {p1_hp_q == '0, p2_hp_q == '0};
        end
      end
      KO: begin
        if (cnt_q == KO_LAST) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (restart) begin
          state_d = FIGHT;
          cnt_d   = '0;
          win_d   = 2'b00;
        end
      end
      default: state_d = FIGHT;
    endcase
  end

  // A hit seen in the last FIGHT cycle would surface during KO
  assign hit_en = (state_q == FIGHT) && (state_d == FIGHT);

  always_comb begin
    att_p2 = hit_en && p1_act && !p1_conn_q && p2_vuln;
    att_p1 = hit_en && p2_act && !p2_conn_q && p1_vuln;

    dmg_p2 = (p2_state == ST_BACK) ? D_CHIP :
             (p1_state == ST_D_ACT) ? D_DIR : D_BASIC;
    dmg_p1 = (p1_state == ST_BACK) ? D_CHIP :
             (p2_state == ST_D_ACT) ? D_DIR : D_BASIC;

    p2_flag_d = 2'b00;
    p1_flag_d = 2'b00;
    p2_hp_d   = p2_hp_q;
    p1_hp_d   = p1_hp_q;
    p1_conn_d = p1_conn_q;
    p2_conn_d = p2_conn_q;

    if (att_p2) begin
      p2_flag_d = (p1_state == ST_D_ACT) ? 2'b10 : 2'b01;
      p2_hp_d   = sat_sub(p2_hp_q, dmg_p2);
      p1_conn_d = 1'b1;
    end else if ((p1_state != ST_B_ACT) &&
                 (p1_state != ST_D_ACT)) begin
      p1_conn_d = 1'b0;
    end

    if (att_p1) begin
      p1_flag_d = (p2_state == ST_D_ACT) ? 2'b10 : 2'b01;
      p1_hp_d   = sat_sub(p1_hp_q, dmg_p1);
      p2_conn_d = 1'b1;
    end else if ((p2_state != ST_B_ACT) &&
                 (p2_state != ST_D_ACT)) begin
      p2_conn_d = 1'b0;
    end

    if ((state_q == DONE) && restart) begin
      p1_hp_d   = HP_MAX;
      p2_hp_d   = HP_MAX;
      p1_conn_d = 1'b0;
      p2_conn_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FIGHT;
      cnt_q     <= '0;
      win_q     <= 2'b00;
      p1_flag_q <= 2'b00;
      p2_flag_q <= 2'b00;
      p1_hp_q   <= HP_MAX;
      p2_hp_q   <= HP_MAX;
      p1_conn_q <= 1'b0;
      p2_conn_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      win_q     <= win_d;
      p1_flag_q <= p1_flag_d;
      p2_flag_q <= p2_flag_d;
      p1_hp_q   <= p1_hp_d;
      p2_hp_q   <= p2_hp_d;
      p1_conn_q <= p1_conn_d;
      p2_conn_q <= p2_conn_d;
    end
  end

  assign p1_hitFlag  = p1_flag_q;
  assign p2_hitFlag  = p2_flag_q;
  assign p1_health   = p1_hp_q;
  assign p2_health   = p2_hp_q;
  assign round_state = state_q;
  assign winner      = win_q;

endmodule

// File: tb/tb_combat_judge.sv
// Self-checking bench for combat_judge: vector table plus
// hand-written KO / restart / mid-KO reset sequences.
module tb_combat_judge;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  p1_state, p2_state;
  logic [39:0] p1_basic_box, p2_basic_box;
  logic [39:0] p1_dir_box, p2_dir_box;
  logic [39:0] p1_hurt_box, p2_hurt_box;
  logic        restart;
  logic [1:0]  p1_hitFlag, p2_hitFlag;
  logic [6:0]  p1_health, p2_health;
  logic [1:0]  round_state, winner;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  combat_judge dut (
    .clk          (clk),
    .rst          (rst),
    .p1_state     (p1_state),
    .p2_state     (p2_state),
    .p1_basic_box (p1_basic_box),
    .p2_basic_box (p2_basic_box),
    .p1_dir_box   (p1_dir_box),
    .p2_dir_box   (p2_dir_box),
    .p1_hurt_box  (p1_hurt_box),
    .p2_hurt_box  (p2_hurt_box),
    .restart      (restart),
    .p1_hitFlag   (p1_hitFlag),
    .p2_hitFlag   (p2_hitFlag),
    .p1_health    (p1_health),
    .p2_health    (p2_health),
    .round_state  (round_state),
    .winner       (winner)
  );

  typedef struct packed {
    logic [1:0] f1;
    logic [1:0] f2;
    logic [6:0] h1;
    logic [6:0] h2;
    logic [1:0] rs;
    logic [1:0] win;
  } exp_t;

  typedef struct {
    logic [3:0]  s1;
    logic [3:0]  s2;
    logic [39:0] b1;
    exp_t        e;
  } vec_t;

  exp_t exp_q[$];
  vec_t tbl[19];

  function automatic logic [39:0] box(int x1, int x2, int y1, int y2);
    return {10'(x1), 10'(x2), 10'(y1), 10'(y2)};
  endfunction

  function automatic exp_t ex(logic [1:0] f1, logic [1:0] f2,
                              int h1, int h2,
                              logic [1:0] rs, logic [1:0] win);
    exp_t e;
    e.f1 = f1; e.f2 = f2;
    e.h1 = 7'(h1); e.h2 = 7'(h2);
    e.rs = rs; e.win = win;
    return e;
  endfunction

  function automatic vec_t mk(int s1, int s2, logic [39:0] b1,
                              logic [1:0] f1, logic [1:0] f2,
                              int h1, int h2);
    vec_t v;
    v.s1 = 4'(s1); v.s2 = 4'(s2); v.b1 = b1;
    v.e  = ex(f1, f2, h1, h2, 2'b00, 2'b00);
    return v;
  endfunction

  task automatic chk(string name, int act, int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic compare(string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk({tag, " scoreboard_empty"}, 0, 1);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, " p1_hitFlag"},  int'(p1_hitFlag),  int'(e.f1));
    chk({tag, " p2_hitFlag"},  int'(p2_hitFlag),  int'(e.f2));
    chk({tag, " p1_health"},   int'(p1_health),   int'(e.h1));
    chk({tag, " p2_health"},   int'(p2_health),   int'(e.h2));
    chk({tag, " round_state"}, int'(round_state), int'(e.rs));
    chk({tag, " winner"},      int'(winner),      int'(e.win));
  endtask

  task automatic step(logic [3:0] s1, logic [3:0] s2,
                      logic [39:0] b1, logic rs_in,
                      exp_t e, string tag);
    @(negedge clk);
    p1_state     = s1;
    p2_state     = s2;
    p1_basic_box = b1;
    restart      = rs_in;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [39:0] a_box, e_box, g_box;
    int h2;

    a_box = box(135, 213, 194, 227);
    e_box = box(150, 200, 194, 227);
    g_box = box(150, 199, 194, 227);

    rst          = 1'b1;
    restart      = 1'b0;
    p1_state     = 4'd0;
    p2_state     = 4'd0;
    p1_basic_box = a_box;
    p1_dir_box   = a_box;
    p2_basic_box = box(900, 950, 900, 950);
    p2_dir_box   = box(0, 40, 10, 20);
    p1_hurt_box  = box(0, 50, 0, 50);
    p2_hurt_box  = box(200, 253, 170, 320);

    tbl[0]  = mk(7, 7,  a_box, 2'b10, 2'b10, 85, 85);
    tbl[1]  = mk(0, 0,  a_box, 2'b00, 2'b00, 85, 85);
    tbl[2]  = mk(4, 0,  a_box, 2'b00, 2'b01, 85, 75);
    tbl[3]  = mk(4, 0,  a_box, 2'b00, 2'b00, 85, 75);
    tbl[4]  = mk(4, 0,  a_box, 2'b00, 2'b00, 85, 75);
    tbl[5]  = mk(0, 0,  a_box, 2'b00, 2'b00, 85, 75);
    tbl[6]  = mk(4, 2,  a_box, 2'b00, 2'b01, 85, 73);
    tbl[7]  = mk(0, 2,  a_box, 2'b00, 2'b00, 85, 73);
    tbl[8]  = mk(4, 9,  a_box, 2'b00, 2'b00, 85, 73);
    tbl[9]  = mk(0, 0,  a_box, 2'b00, 2'b00, 85, 73);
    tbl[10] = mk(4, 10, a_box, 2'b00, 2'b00, 85, 73);
    tbl[11] = mk(0, 0,  a_box, 2'b00, 2'b00, 85, 73);
    tbl[12] = mk(3, 0,  a_box, 2'b00, 2'b00, 85, 73);
    tbl[13] = mk(5, 0,  a_box, 2'b00, 2'b00, 85, 73);
    tbl[14] = mk(4, 0,  g_box, 2'b00, 2'b00, 85, 73);
    tbl[15] = mk(4, 0,  e_box, 2'b00, 2'b01, 85, 63);
    tbl[16] = mk(0, 0,  a_box, 2'b00, 2'b00, 85, 63);
    tbl[17] = mk(2, 7,  a_box, 2'b10, 2'b00, 83, 63);
    tbl[18] = mk(0, 0,  a_box, 2'b00, 2'b00, 83, 63);

    #2;
    exp_q.push_back(ex(2'b00, 2'b00, 100, 100, 2'b00, 2'b00));
    compare("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      step(tbl[i].s1, tbl[i].s2, tbl[i].b1, 1'b0, tbl[i].e,
           $sformatf("row%0d", i));
    end

    // drain P2 to zero; the last basic hit saturates 3 -> 0
    h2 = 63;
    for (int i = 0; i < 7; i++) begin
      h2 = (h2 > 10) ? h2 - 10 : 0;
      step(4'd4, 4'd0, a_box, 1'b0,
           ex(2'b00, 2'b01, 83, h2, 2'b00, 2'b00), "ko_hit");
      step(4'd0, 4'd0, a_box, 1'b0,
           ex(2'b00, 2'b00, 83, h2,
              (h2 == 0) ? 2'b01 : 2'b00,
              (h2 == 0) ? 2'b01 : 2'b00), "ko_idle");
    end

    // KO holds 90 frames; hits and restart are ignored there
    for (int j = 1; j < 90; j++) begin
      step(4'd0, (j < 5) ? 4'd7 : 4'd0, a_box, 1'(j % 2),
           ex(2'b00, 2'b00, 83, 0, 2'b01, 2'b01), "ko_hold");
    end
    step(4'd0, 4'd0, a_box, 1'b0,
         ex(2'b00, 2'b00, 83, 0, 2'b10, 2'b01), "ko_done");
    step(4'd0, 4'd0, a_box, 1'b0,
         ex(2'b00, 2'b00, 83, 0, 2'b10, 2'b01), "done_hold");
    step(4'd0, 4'd0, a_box, 1'b1,
         ex(2'b00, 2'b00, 100, 100, 2'b00, 2'b00), "restart");

    h2 = 100;
    for (int i = 0; i < 10; i++) begin
      h2 = h2 - 10;
      step(4'd4, 4'd0, a_box, 1'b0,
           ex(2'b00, 2'b01, 100, h2, 2'b00, 2'b00), "r2_hit");
      step(4'd0, 4'd0, a_box, 1'b0,
           ex(2'b00, 2'b00, 100, h2,
              (h2 == 0) ? 2'b01 : 2'b00,
              (h2 == 0) ? 2'b01 : 2'b00), "r2_idle");
    end
    for (int j = 1; j <= 40; j++) begin
      step(4'd0, 4'd0, a_box, 1'b0,
           ex(2'b00, 2'b00, 100, 0, 2'b01, 2'b01), "r2_ko");
    end

    @(negedge clk);
    rst = 1'b1;
    #1;
    exp_q.push_back(ex(2'b00, 2'b00, 100, 100, 2'b00, 2'b00));
    compare("mid_ko_reset");
    @(negedge clk);
    rst = 1'b0;

    for (int j = 0; j < 100; j++) begin
      step(4'd0, 4'd0, a_box, 1'b0,
           ex(2'b00, 2'b00, 100, 100, 2'b00, 2'b00), "post_rst");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/combat_judge.md
Name: combat_judge

Overview:
- Arbitrates combat between the two player instances. Each cycle it takes both players' state and hit/hurt boxes, detects active-hitbox vs hurtbox overlap and issues the registered hitFlag that each player consumes.
- Tracks health for both players with saturating damage.
- Runs the round state machine: FIGHT -> KO -> DONE -> restart.
- Sits between the two player blocks and the renderer/HUD.

Parameters:
- MAX_HEALTH, 100, health loaded at reset/restart (must be <= 2^HP_W-1)
- HP_W, 7, health counter width
- DMG_BASIC, 10, damage of an unblocked basic hit
- DMG_DIR, 15, damage of an unblocked directional hit
- DMG_CHIP, 2, damage of any blocked hit
- KO_FRAMES, 90, cycles spent in KO before DONE

Ports:
- clk  in  1  clock, one cycle per game frame
- rst  in  1  reset, asynchronous, active-high
- p1_state, p2_state  in  4  player current_state (0 idle, 1 fwd, 2 back, 3-5 basic start/end/pull, 6-8 dir start/end/pull, 9 hitstun, 10 blockstun)
- p1_basic_box, p2_basic_box  in  40  packed {x1,x2,y1,y2}, 10 bits each, basic hitbox
- p1_dir_box, p2_dir_box  in  40  packed {x1,x2,y1,y2}, directional hitbox
- p1_hurt_box, p2_hurt_box  in  40  packed {x1,x2,y1,y2}, main hurtbox
- restart  in  1  level; starts a new round when in DONE
- p1_hitFlag, p2_hitFlag  out  2  flag delivered to that player: 00 none, 01 hit by basic, 10 hit by directional
- p1_health, p2_health  out  HP_W  current health
- round_state  out  2  00 FIGHT, 01 KO, 10 DONE
- winner  out  2  00 none, 01 P1, 10 P2, 11 draw

Behaviour:
- Reset (async):
  - hitFlags = 00, health = MAX_HEALTH, round_state = FIGHT, winner = 00.
  - Connected latches and KO counter = 0.
- Overlap is inclusive on all edges: (a.x1 <= b.x2) && (b.x1 <= a.x2) && (a.y1 <= b.y2) && (b.y1 <= a.y2). Compare unsigned 10-bit.
- Active hitbox:
  - basic_box only while attacker state == 4.
  - dir_box only while attacker state == 7.
  - No other state produces a hit.
- Attack on P2 (P1 -> P2 is symmetric): raised when all of the following hold:
  - round_state == FIGHT;
  - P1's active box overlaps p2_hurt_box;
  - p1_connected == 0;
  - p2_state is not 9 or 10 (stunned defenders are invulnerable).
- Connected latch: p1_connected sets on an attack. It clears in the first cycle p1_state is neither 4 nor 7. This gives one hit per attack activation.
- Flag timing:
  - p2_hitFlag is registered. It is 01/10 for exactly one cycle, the cycle after the overlap is seen, then 00.
  - The player consumes the flag combinationally in that cycle.
- Damage is applied in the same edge as the flag.
  - Blocked (p2_state == 2 at detection): DMG_CHIP.
  - Otherwise: DMG_BASIC or DMG_DIR.
  - Health saturates at 0; no wrap.
- Trades: simultaneous attacks in both directions in the same cycle are both delivered and both damage applied.
- Round FSM:
  - FIGHT -> KO on the edge after either health is 0. winner is latched then: 01 if p2 = 0 only, 10 if p1 = 0 only, 11 if both.
  - KO: counter counts to KO_FRAMES-1, then -> DONE. No hits in KO or DONE; flags forced 00.
  - DONE -> FIGHT when restart = 1. Health reloads to MAX_HEALTH; winner, latches and counter clear.
  - restart is ignored in FIGHT/KO.
- Reset asserted mid-round returns everything to reset values immediately; the KO counter does not resume.

Test Plan:
- Reset, P1 state 4, P1 basic box {135,213,194,227} overlapping P2 hurt {459,512,170,320}? No; use P2 hurt {200,253,170,320}, P2 state 0 -> p2_hitFlag = 01 for one cycle, p2_health 100 -> 90. Holding state 4 for 2 more cycles gives no further flag.
- Same overlap with p2_state = 2 -> flag 01, p2_health 100 -> 98. Same overlap with p2_state = 9 -> flag 00, health unchanged.
- Both players in state 7 with mutually overlapping dir boxes -> both hitFlags 10 in the same cycle, both health 100 -> 85.
- Edge-touching boxes (attacker x2 = 200 == defender x1 = 200) count as a hit. A gap of 1 (x2 = 199) gives no hit.
- Force p2_health to 5, then an unblocked basic hit -> p2_health = 0 (saturated). round_state -> KO next edge, winner = 01. After 90 cycles DONE. restart = 1 -> FIGHT, both health 100, winner 00.
- Assert rst during KO at count 40 -> round_state FIGHT, health 100, flags 00 immediately. After release, no DONE transition without a new KO.
